// File: rtl/inst_fetch_unit_if.sv
// Fetch-stage bus: instruction SRAM read port, branch redirect input and the
// valid/ready handshake towards decode.
interface inst_fetch_unit_if;
  logic        inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        br_redirect;
  logic [31:0] br_target;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_adef;

  modport master (
    output inst_sram_we, inst_sram_addr, inst_sram_wdata,
    input  inst_sram_rdata,
    input  br_redirect, br_target, id_ready,
    output if_valid, if_pc, if_inst, if_adef
  );

  modport slave (
    input  inst_sram_we, inst_sram_addr, inst_sram_wdata,
    output inst_sram_rdata,
    output br_redirect, br_target, id_ready,
    input  if_valid, if_pc, if_inst, if_adef
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Multi-cycle instruction fetch: owns the PC, waits out the SRAM read latency and
// presents one {pc, inst} pair to decode under valid/ready, with branch redirect.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000,
  parameter int          SRAM_LAT = 1
) (
  input logic               clk,
  input logic               reset,
  inst_fetch_unit_if.master bus
);
  localparam logic [1:0] LAT = 2'(SRAM_LAT);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    ADEF  = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic [31:0] pc;
  logic [31:0] pc_inc;
  logic        if_valid_r;
  logic        if_adef_r;
  logic [31:0] if_pc_r;
  logic [31:0] if_inst_r;

  assign pc_inc = pc + 32'd4;

  assign bus.inst_sram_we    = 1'b0;
  assign bus.inst_sram_wdata = 32'd0;
  assign bus.inst_sram_addr  = pc;
  assign bus.if_valid        = if_valid_r;
  assign bus.if_pc           = if_pc_r;
  assign bus.if_inst         = if_inst_r;
  assign bus.if_adef         = if_adef_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_PC;
      state      <= FETCH;
      cnt        <= 2'd0;
      if_valid_r <= 1'b0;
      if_inst_r  <= 32'd0;
      if_pc_r    <= RESET_PC;
      if_adef_r  <= 1'b0;
    end else if (bus.br_redirect) begin
      // Redirect beats capture and handshake: in-flight data and a same-cycle accept are dropped.
      pc         <= bus.br_target;
      if_valid_r <= 1'b0;
      cnt        <= 2'd0;
      state      <= (bus.br_target[1:0] != 2'b00) ? ADEF : FETCH;
    end else begin
      case (state)
        FETCH: begin
          cnt <= cnt + 2'd1;
          if (cnt == LAT) begin
            if_inst_r  <= bus.inst_sram_rdata;
            if_pc_r    <= pc;
            if_adef_r  <= 1'b0;
            if_valid_r <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (if_valid_r && bus.id_ready) begin
            pc         <= pc_inc;
            if_valid_r <= 1'b0;
            cnt        <= 2'd0;
            // pc+4 keeps the low bits, so a misaligned stream stays on the ADEF path.
            state      <= (pc_inc[1:0] != 2'b00) ? ADEF : FETCH;
          end
        end
        ADEF: begin
          if_valid_r <= 1'b1;
          if_pc_r    <= pc;
          if_inst_r  <= 32'd0;
          if_adef_r  <= 1'b1;
          state      <= HOLD;
        end
        default: begin
          state <= FETCH;
          cnt   <= 2'd0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: two instances (SRAM latency 1 and 3) share stimulus,
// each fed by a delayed-data SRAM model; directed scenarios plus a randomized run.
module tb_inst_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        br_redirect;
  logic [31:0] br_target;
  logic        id_ready;
  int          checks;
  int          errors;

  inst_fetch_unit_if b0 ();
  inst_fetch_unit_if b1 ();

  inst_fetch_unit #(.RESET_PC(RST_PC), .SRAM_LAT(1)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  inst_fetch_unit #(.RESET_PC(RST_PC), .SRAM_LAT(3)) dut1 (.clk(clk), .reset(reset), .bus(b1));

  always #5 clk = ~clk;

  assign b0.br_redirect = br_redirect;
  assign b0.br_target   = br_target;
  assign b0.id_ready    = id_ready;
  assign b1.br_redirect = br_redirect;
  assign b1.br_target   = br_target;
  assign b1.id_ready    = id_ready;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // SRAM models: data for an address appears SRAM_LAT cycles after it is presented
  logic [31:0] pipe0;
  logic [31:0] pipe1 [3];
  always @(posedge clk) begin
    pipe0    <= mem(b0.inst_sram_addr);
    pipe1[0] <= mem(b1.inst_sram_addr);
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
  end
  assign b0.inst_sram_rdata = pipe0;
  assign b1.inst_sram_rdata = pipe1[2];

  logic        o_valid [2];
  logic        o_adef  [2];
  logic [31:0] o_pc    [2];
  logic [31:0] o_inst  [2];
  logic [31:0] o_addr  [2];
  assign o_valid[0] = b0.if_valid;  assign o_valid[1] = b1.if_valid;
  assign o_adef[0]  = b0.if_adef;   assign o_adef[1]  = b1.if_adef;
  assign o_pc[0]    = b0.if_pc;     assign o_pc[1]    = b1.if_pc;
  assign o_inst[0]  = b0.if_inst;   assign o_inst[1]  = b1.if_inst;
  assign o_addr[0]  = b0.inst_sram_addr;
  assign o_addr[1]  = b1.inst_sram_addr;

  // Transaction-level reference: pc stream plus cycles since the current fetch began
  logic [31:0] m_pc    [2];
  int          m_since [2];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    br_redirect = 1'b0;
    br_target   = 32'd0;
    id_ready    = 1'b0;
    repeat (4) cyc();
    reset = 1'b0;
  endtask

  // Cycles until if_valid of instance k is seen, -1 if it never appears within maxc
  task automatic wait_valid(input int k, input int maxc, output int n);
    n = 0;
    while (!o_valid[k] && n < maxc) begin
      cyc();
      n++;
    end
    if (!o_valid[k]) n = -1;
  endtask

  task automatic test_reset();
    int n;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({o_valid[k], o_adef[k], o_pc[k], o_inst[k], o_addr[k]} !== {1'b0, 1'b0, RST_PC, 32'd0, RST_PC}) begin
        errors++;
        $display("FAIL reset_state[%0d]: got v=%b adef=%b pc=%h inst=%h addr=%h, want v=0 adef=0 pc=%h inst=0 addr=%h",
                 k, o_valid[k], o_adef[k], o_pc[k], o_inst[k], o_addr[k], RST_PC, RST_PC);
      end
    end
    checks++;
    if ({b0.inst_sram_we, b0.inst_sram_wdata, b1.inst_sram_we, b1.inst_sram_wdata} !== 66'd0) begin
      errors++;
      $display("FAIL sram_write_tieoff: got we=%b/%b wdata=%h/%h, want all 0",
               b0.inst_sram_we, b1.inst_sram_we, b0.inst_sram_wdata, b1.inst_sram_wdata);
    end
    // Reset while holding with id_ready high: no handshake may complete
    wait_valid(0, 10, n);
    reset    = 1'b1;
    id_ready = 1'b1;
    cyc();
    reset    = 1'b0;
    id_ready = 1'b0;
    checks++;
    if ({o_valid[0], o_addr[0], o_pc[0], o_inst[0]} !== {1'b0, RST_PC, RST_PC, 32'd0}) begin
      errors++;
      $display("FAIL reset_mid_hold: got v=%b addr=%h pc=%h inst=%h, want v=0 addr=%h pc=%h inst=0",
               o_valid[0], o_addr[0], o_pc[0], o_inst[0], RST_PC, RST_PC);
    end
  endtask

  task automatic test_sequential();
    int n;
    logic [31:0] epc;
    do_reset();
    id_ready = 1'b1;
    wait_valid(0, 10, n);
    checks++;
    if ({n, o_pc[0], o_inst[0]} !== {32'sd2, RST_PC, 32'hB9A5_0000}) begin
      errors++;
      $display("FAIL first_fetch: got latency=%0d pc=%h inst=%h, want latency=2 pc=%h inst=b9a50000",
               n, o_pc[0], o_inst[0], RST_PC);
    end
    for (int i = 1; i <= 2; i++) begin
      cyc();
      wait_valid(0, 10, n);
      epc = RST_PC + 32'(4 * i);
      checks++;
      if ({n + 1, o_pc[0], o_inst[0], o_adef[0]} !== {32'sd3, epc, mem(epc), 1'b0}) begin
        errors++;
        $display("FAIL seq_fetch%0d: got spacing=%0d pc=%h inst=%h adef=%b, want spacing=3 pc=%h inst=%h adef=0",
                 i, n + 1, o_pc[0], o_inst[0], o_adef[0], epc, mem(epc));
      end
    end
    id_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int n;
    logic [31:0] pc0, inst0, addr0;
    do_reset();
    wait_valid(0, 10, n);
    pc0 = o_pc[0]; inst0 = o_inst[0]; addr0 = o_addr[0];
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if ({o_valid[0], o_pc[0], o_inst[0], o_addr[0]} !== {1'b1, pc0, inst0, addr0}) begin
        errors++;
        $display("FAIL stall_hold%0d: got v=%b pc=%h inst=%h addr=%h, want v=1 pc=%h inst=%h addr=%h",
                 i, o_valid[0], o_pc[0], o_inst[0], o_addr[0], pc0, inst0, addr0);
      end
    end
    id_ready = 1'b1;
    cyc();
    id_ready = 1'b0;
    checks++;
    if ({o_valid[0], o_addr[0]} !== {1'b0, pc0 + 32'd4}) begin
      errors++;
      $display("FAIL stall_release: got v=%b addr=%h, want v=0 addr=%h", o_valid[0], o_addr[0], pc0 + 32'd4);
    end
    wait_valid(0, 10, n);
    checks++;
    if ({n, o_pc[0], o_inst[0]} !== {32'sd2, pc0 + 32'd4, mem(pc0 + 32'd4)}) begin
      errors++;
      $display("FAIL stall_next: got latency=%0d pc=%h inst=%h, want latency=2 pc=%h inst=%h",
               n, o_pc[0], o_inst[0], pc0 + 32'd4, mem(pc0 + 32'd4));
    end
  endtask

  task automatic test_redirect_fetch();
    int n;
    do_reset();
    br_redirect = 1'b1;
    br_target   = 32'h1c00_0100;
    cyc();
    br_redirect = 1'b0;
    checks++;
    if ({o_valid[0], o_addr[0]} !== {1'b0, 32'h1c00_0100}) begin
      errors++;
      $display("FAIL redir_fetch_now: got v=%b addr=%h, want v=0 addr=1c000100", o_valid[0], o_addr[0]);
    end
    wait_valid(0, 10, n);
    checks++;
    if ({n, o_pc[0], o_inst[0]} !== {32'sd2, 32'h1c00_0100, mem(32'h1c00_0100)}) begin
      errors++;
      $display("FAIL redir_fetch_next: got latency=%0d pc=%h inst=%h, want latency=2 pc=1c000100 inst=%h",
               n, o_pc[0], o_inst[0], mem(32'h1c00_0100));
    end
    // Redirect on the very cycle the SRAM word would be captured
    do_reset();
    cyc();
    br_redirect = 1'b1;
    br_target   = 32'h1c00_0140;
    cyc();
    br_redirect = 1'b0;
    checks++;
    if ({o_valid[0], o_addr[0]} !== {1'b0, 32'h1c00_0140}) begin
      errors++;
      $display("FAIL redir_capture_drop: got v=%b addr=%h, want v=0 addr=1c000140", o_valid[0], o_addr[0]);
    end
  endtask

  task automatic test_redirect_hold();
    int n;
    do_reset();
    wait_valid(0, 10, n);
    id_ready    = 1'b1;
    br_redirect = 1'b1;
    br_target   = 32'h1c00_0200;
    cyc();
    id_ready    = 1'b0;
    br_redirect = 1'b0;
    checks++;
    if ({o_valid[0], o_addr[0]} !== {1'b0, 32'h1c00_0200}) begin
      errors++;
      $display("FAIL redir_hold_pc: got v=%b addr=%h, want v=0 addr=1c000200", o_valid[0], o_addr[0]);
    end
    wait_valid(0, 10, n);
    checks++;
    if ({n, o_pc[0], o_inst[0]} !== {32'sd2, 32'h1c00_0200, mem(32'h1c00_0200)}) begin
      errors++;
      $display("FAIL redir_hold_next: got latency=%0d pc=%h inst=%h, want latency=2 pc=1c000200 inst=%h",
               n, o_pc[0], o_inst[0], mem(32'h1c00_0200));
    end
  endtask

  task automatic test_adef();
    do_reset();
    br_redirect = 1'b1;
    br_target   = 32'h1c00_0102;
    cyc();
    br_redirect = 1'b0;
    checks++;
    if ({o_valid[0], o_addr[0]} !== {1'b0, 32'h1c00_0102}) begin
      errors++;
      $display("FAIL adef_redirect: got v=%b addr=%h, want v=0 addr=1c000102", o_valid[0], o_addr[0]);
    end
    cyc();
    checks++;
    if ({o_valid[0], o_adef[0], o_inst[0], o_pc[0]} !== {1'b1, 1'b1, 32'd0, 32'h1c00_0102}) begin
      errors++;
      $display("FAIL adef_present: got v=%b adef=%b inst=%h pc=%h, want v=1 adef=1 inst=0 pc=1c000102",
               o_valid[0], o_adef[0], o_inst[0], o_pc[0]);
    end
    id_ready = 1'b1;
    cyc();
    id_ready = 1'b0;
    cyc();
    checks++;
    if ({o_valid[0], o_adef[0], o_inst[0], o_pc[0]} !== {1'b1, 1'b1, 32'd0, 32'h1c00_0106}) begin
      errors++;
      $display("FAIL adef_advance: got v=%b adef=%b inst=%h pc=%h, want v=1 adef=1 inst=0 pc=1c000106",
               o_valid[0], o_adef[0], o_inst[0], o_pc[0]);
    end
  endtask

  task automatic test_wrap();
    int n;
    do_reset();
    br_redirect = 1'b1;
    br_target   = 32'hffff_fffc;
    cyc();
    br_redirect = 1'b0;
    wait_valid(0, 10, n);
    id_ready = 1'b1;
    cyc();
    id_ready = 1'b0;
    wait_valid(0, 10, n);
    checks++;
    if ({n, o_pc[0], o_inst[0], o_addr[0]} !== {32'sd2, 32'd0, 32'hA5A5_0000, 32'd0}) begin
      errors++;
      $display("FAIL pc_wrap: got latency=%0d pc=%h inst=%h addr=%h, want latency=2 pc=0 inst=a5a50000 addr=0",
               n, o_pc[0], o_inst[0], o_addr[0]);
    end
  endtask

  task automatic test_lat3();
    int n;
    do_reset();
    id_ready = 1'b1;
    wait_valid(1, 12, n);
    checks++;
    if ({n, o_pc[1], o_inst[1]} !== {32'sd4, RST_PC, mem(RST_PC)}) begin
      errors++;
      $display("FAIL lat3_first: got latency=%0d pc=%h inst=%h, want latency=4 pc=%h inst=%h",
               n, o_pc[1], o_inst[1], RST_PC, mem(RST_PC));
    end
    cyc();
    wait_valid(1, 12, n);
    checks++;
    if ({n, o_pc[1], o_inst[1]} !== {32'sd4, RST_PC + 32'd4, mem(RST_PC + 32'd4)}) begin
      errors++;
      $display("FAIL lat3_second: got latency=%0d pc=%h inst=%h, want latency=4 pc=%h inst=%h",
               n, o_pc[1], o_inst[1], RST_PC + 32'd4, mem(RST_PC + 32'd4));
    end
    cyc();
    id_ready = 1'b0;
    cyc();
    cyc();
    br_redirect = 1'b1;
    br_target   = 32'h1c00_0300;
    cyc();
    br_redirect = 1'b0;
    checks++;
    if (o_valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL lat3_redir_drop: got v=%b, want v=0", o_valid[1]);
    end
    wait_valid(1, 12, n);
    checks++;
    if ({n, o_pc[1], o_inst[1]} !== {32'sd4, 32'h1c00_0300, mem(32'h1c00_0300)}) begin
      errors++;
      $display("FAIL lat3_redir_next: got latency=%0d pc=%h inst=%h, want latency=4 pc=1c000300 inst=%h",
               n, o_pc[1], o_inst[1], mem(32'h1c00_0300));
    end
  endtask

  task automatic test_random();
    int  need;
    logic ev;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k]    = RST_PC;
      m_since[k] = 0;
    end
    for (int c = 0; c < 400; c++) begin
      id_ready    = ($urandom_range(0, 3) != 0);
      br_redirect = ($urandom_range(0, 11) == 0);
      br_target   = {12'h1c0, 18'($urandom), 2'b00};
      if ($urandom_range(0, 3) == 0) br_target[1:0] = 2'($urandom_range(1, 3));
      for (int k = 0; k < 2; k++) begin
        if (br_redirect) begin
          m_pc[k]    = br_target;
          m_since[k] = 0;
        end else if (o_valid[k] && id_ready) begin
          m_pc[k]    = m_pc[k] + 32'd4;
          m_since[k] = 0;
        end else if (m_since[k] < 1000) begin
          m_since[k]++;
        end
      end
      cyc();
      for (int k = 0; k < 2; k++) begin
        need = (m_pc[k][1:0] != 2'b00) ? 1 : lat_of(k) + 1;
        ev   = (m_since[k] >= need);
        checks++;
        if ({o_valid[k], o_addr[k]} !== {ev, m_pc[k]}) begin
          errors++;
          $display("FAIL rand_ctrl[%0d] cycle %0d: got v=%b addr=%h, want v=%b addr=%h",
                   k, c, o_valid[k], o_addr[k], ev, m_pc[k]);
        end
        if (ev && o_valid[k]) begin
          checks++;
          if ({o_pc[k], o_adef[k], o_inst[k]} !==
              {m_pc[k], (need == 1), (need == 1) ? 32'd0 : mem(m_pc[k])}) begin
            errors++;
            $display("FAIL rand_data[%0d] cycle %0d: got pc=%h adef=%b inst=%h, want pc=%h adef=%b inst=%h",
                     k, c, o_pc[k], o_adef[k], o_inst[k], m_pc[k], (need == 1),
                     (need == 1) ? 32'd0 : mem(m_pc[k]));
          end
        end
      end
    end
    br_redirect = 1'b0;
    id_ready    = 1'b0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    br_redirect = 1'b0;
    br_target   = 32'd0;
    id_ready    = 1'b0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_fetch();
    test_redirect_hold();
    test_adef();
    test_wrap();
    test_lat3();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Multi-cycle instruction fetch stage. It sits directly upstream of the CPU's decode/execute control FSM. It owns the PC, drives the instruction SRAM read port, and waits out the SRAM read latency. It then presents one {pc, inst} pair to decode under a valid/ready handshake. Branch/jump redirects from downstream replace the PC and squash any fetch in flight.

Parameters:
RESET_PC, 32'h1c00_0000, first fetch address after reset.
SRAM_LAT, 1, inst SRAM read latency in cycles: rdata reflects the addr presented SRAM_LAT cycles earlier. Legal values are 1..3.

Ports:
clk  in  1  single clock, all state updates on posedge.
reset  in  1  synchronous, active-high reset.
inst_sram_we  out  1  constant 0.
inst_sram_addr  out  32  fetch address, combinational from internal pc register.
inst_sram_wdata  out  32  constant 0.
inst_sram_rdata  in  32  SRAM read data.
br_redirect  in  1  one-cycle pulse: downstream resolved a taken branch/jump.
br_target  in  32  redirect address, sampled when br_redirect=1.
id_ready  in  1  decode can accept the held instruction this cycle.
if_valid  out  1  {if_pc, if_inst, if_adef} valid for decode.
if_pc  out  32  PC of the presented instruction.
if_inst  out  32  fetched instruction word.
if_adef  out  1  presented PC is misaligned (pc[1:0]!=0); if_inst=0.

Behaviour:
- Reset (reset=1 at a clk edge):
  - pc=RESET_PC, state=FETCH, cnt=0.
  - if_valid=0, if_inst=0, if_pc=RESET_PC, if_adef=0.
  - Reset mid-fetch or mid-hold discards everything; no handshake completes in a reset cycle.
- inst_sram_addr=pc at all times; pc changes only on handshake or redirect. SRAM sees a stable address for the whole FETCH.
- State FETCH:
  - cnt increments every cycle.
  - When cnt==SRAM_LAT: if_inst<=inst_sram_rdata, if_pc<=pc, if_adef<=0, if_valid<=1, state<=HOLD.
  - FETCH therefore lasts SRAM_LAT+1 cycles. if_valid rises SRAM_LAT+1 cycles after FETCH entry.
- State HOLD:
  - if_valid=1. Outputs are held stable while id_ready=0, for unbounded stalls.
  - Handshake = if_valid & id_ready. On handshake: pc<=pc+4 (mod 2^32, wraps 0xffff_fffc->0), if_valid<=0, cnt<=0, state<=FETCH.
- Redirect (br_redirect=1) in any state, higher priority than handshake and capture:
  - pc<=br_target, if_valid<=0, cnt<=0.
  - A same-cycle handshake is NOT counted as accepted by fetch; the downstream FSM issuing the redirect must ignore it.
  - An SRAM result due in the same cycle is dropped.
- Misaligned next pc (br_target[1:0]!=0 on redirect):
  - Next state is ADEF instead of FETCH; no SRAM wait.
  - ADEF lasts one cycle, then: if_valid<=1, if_pc<=pc, if_inst<=0, if_adef<=1, state<=HOLD.
  - The handshake from this HOLD advances pc by 4, still misaligned, so the unit stays in the ADEF path. Downstream is expected to redirect on if_adef.
- Throughput: one instruction per SRAM_LAT+2 cycles with id_ready tied 1. With SRAM_LAT=1 that is 3 cycles.
- States: FETCH, HOLD, ADEF. 2-bit encoding; illegal encodings go to FETCH with cnt=0.
- No combinational path from id_ready or br_redirect to any output.

Test Plan:
1. Reset, SRAM_LAT=1, SRAM returns addr^32'hA5A5_0000, id_ready=1 -> first if_valid 2 cycles after reset deasserts with if_pc=1c00_0000, inst=B9A5_0000. Next handshakes carry 1c00_0004 and 1c00_0008, 3 cycles apart.
2. Backpressure: hold id_ready=0 for 5 cycles in HOLD -> if_valid, if_pc, if_inst unchanged and inst_sram_addr constant. Raising id_ready gives exactly one handshake, then pc+4.
3. Redirect during FETCH (cnt=0) with br_target=1c00_0100 -> the old fetch is dropped and no if_valid appears for it. The next presented if_pc is 1c00_0100, 2 cycles after the redirect.
4. Redirect in HOLD in the same cycle as id_ready=1, br_target=1c00_0200 -> pc=1c00_0200 (not old pc+4); the next instruction presented has if_pc=1c00_0200.
5. Redirect to 1c00_0102 -> one cycle later if_valid=1, if_adef=1, if_inst=0, if_pc=1c00_0102. No SRAM capture is used.
6. SRAM_LAT=3 with a delayed-data model -> if_valid 4 cycles after FETCH entry, with the correct word for each pc. A redirect at cnt=2 yields no stale instruction.
